// File: rtl/counter_mod_updown_if.sv
// Control and status bundle for one counter_mod_updown stage.
// The master drives the count controls; the slave (the counter) returns count and flags.
interface counter_mod_updown_if #(
  parameter int N_BITS = 3
);
  logic              en;
  logic              ripple_in;
  logic              up_dn;
  logic              load;
  logic [N_BITS-1:0] load_val;
  logic [1:0]        mode;
  logic [N_BITS-1:0] count;
  logic              ripple;
  logic              overflow;
  logic              done;

  modport master (
    output en, ripple_in, up_dn, load, load_val, mode,
    input  count, ripple, overflow, done
  );

  modport slave (
    input  en, ripple_in, up_dn, load, load_val, mode,
    output count, ripple, overflow, done
  );
endinterface

// File: rtl/counter_mod_updown.sv
// Up/down counter modulo MAX_VAL+1 with load, enable, chain carry and
// wrap / saturate / one-shot terminal-count modes.
module counter_mod_updown #(
  parameter int N_BITS  = 3,
  parameter int MAX_VAL = 2**N_BITS - 1
) (
  input logic                 clk,
  input logic                 asyn_rst,
  counter_mod_updown_if.slave bus
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [N_BITS-1:0] MAX_C  = N_BITS'(MAX_VAL);
  localparam logic [N_BITS-1:0] ZERO_C = '0;
  localparam logic [N_BITS-1:0] ONE_C  = N_BITS'(1);

  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_ONCE = 2'b10;

  state_t            state_q, state_d;
  logic [N_BITS-1:0] count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              step;
  logic              term;

  always_comb begin
    step = bus.en & bus.ripple_in & (state_q == ST_RUN);
    term = bus.up_dn ? (count_q == MAX_C) : (count_q == ZERO_C);
  end

  // Carry-out stays combinational so a whole chain advances on one edge.
  assign bus.ripple   = step & term;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.done     = (state_q == ST_HALT);

  always_comb begin
    count_d    = count_q;
    overflow_d = 1'b0;
    state_d    = state_q;

    if (bus.load) begin
      count_d = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
      state_d = ST_RUN;
    end else begin
      if ((state_q == ST_HALT) && (bus.mode != MODE_ONCE)) begin
        state_d = ST_RUN;
      end

      if (step) begin
        if (!term) begin
          count_d = bus.up_dn ? (count_q + ONE_C) : (count_q - ONE_C);
        end else begin
          case (bus.mode)
            MODE_SAT: begin
              overflow_d = 1'b1;
            end
            MODE_ONCE: begin
              state_d = ST_HALT;
            end
            default: begin
              count_d    = bus.up_dn ? ZERO_C : MAX_C;
              overflow_d = 1'b1;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_RUN;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

endmodule
